// File: rtl/dense_forward_if.sv
// dense_forward_if: bundle between the dense-layer forward stage and its driver.
//
// Parameters
//   M  output rows (neurons)
//   N  input columns (features)
//
// Signals (all data are 32-bit signed fixed point)
//   start  request one forward pass
//   x      input activation column, [0:N-1][0:0]
//   w      weight matrix, [0:M-1][0:N-1]
//   b      bias column, [0:M-1][0:0]
//   z      pre-activation output column, [0:M-1][0:0]
//   busy   pass in progress
//   done   one-cycle pulse when all of z is valid
//
// Modports: master = driver side, slave = dense_forward side.
interface dense_forward_if #(
    parameter int unsigned M = 5,
    parameter int unsigned N = 4
);
    logic               start;
    logic signed [31:0] x [0:N-1][0:0];
    logic signed [31:0] w [0:M-1][0:N-1];
    logic signed [31:0] b [0:M-1][0:0];
    logic signed [31:0] z [0:M-1][0:0];
    logic               busy;
    logic               done;

    modport master (
        output start, x, w, b,
        input  z, busy, done
    );

    modport slave (
        input  start, x, w, b,
        output z, busy, done
    );
endinterface

// File: rtl/dense_forward.sv
// dense_forward: fixed-point dense-layer forward stage, z = W*x + b.
//
// One multiply-accumulate per cycle. The FSM walks W row by row (N MAC cycles
// then one WRITE cycle per row), rescales each row sum by an arithmetic right
// shift of FRAC_BITS (truncation toward -inf), adds the bias and writes z[i].
// A one-cycle done pulse follows the last row.
//
// Ports
//   clk    clock, rising edge
//   reset  synchronous, active-low; returns to IDLE and clears acc, counters, z
//   bus    dense_forward_if.slave: start/x/w/b in, z/busy/done out
//
// Parameters
//   M, N       rows / columns of W; must match the interface instance
//   FRAC_BITS  fractional bits of x, w, b and z
//
// Configuration macro
//   DENSE_SATURATE_EN  defined: clamp each result to the 32-bit signed range
//                      undefined: keep the low 32 bits (wraps)
module dense_forward #(
    parameter int unsigned M         = 5,
    parameter int unsigned N         = 4,
    parameter int unsigned FRAC_BITS = 12
) (
    input logic           clk,
    input logic           reset,
    dense_forward_if.slave bus
);
    // Sum of N full 64-bit products cannot overflow this width.
    localparam int unsigned AW = 64 + $clog2(N);
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [IW-1:0]         i_q, i_d;
    logic [JW-1:0]         j_q, j_d;
    logic                  busy_q, done_q;
    logic signed [31:0]    z_q [0:M-1][0:0];
    logic                  z_we;
    logic signed [63:0]    prod;
    logic signed [31:0]    z_val;

    assign prod = 64'(bus.x[j_q][0]) * 64'(bus.w[i_q][j_q]);

`ifdef DENSE_SATURATE_EN
    localparam logic signed [AW:0] ZMax = (AW+1)'(64'sh0000_0000_7fff_ffff);
    localparam logic signed [AW:0] ZMin = (AW+1)'(-64'sh0000_0000_8000_0000);

    logic signed [AW:0] sum;

    assign sum = (AW+1)'(acc_q >>> FRAC_BITS) + (AW+1)'(bus.b[i_q][0]);

    always_comb begin
        if (sum > ZMax) begin
            z_val = 32'sh7fff_ffff;
        end else if (sum < ZMin) begin
            z_val = 32'sh8000_0000;
        end else begin
            z_val = 32'(sum);
        end
    end
`else
    // Only the low 32 bits survive, so the add can be done at 32 bits.
    assign z_val = 32'(acc_q >>> FRAC_BITS) + bus.b[i_q][0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        z_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + AW'(prod);
                j_d   = j_q + JW'(1);
                if (j_q == JW'(N - 1)) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                z_we  = 1'b1;
                acc_d = '0;
                j_d   = '0;
                if (i_q == IW'(M - 1)) begin
                    state_d = StDone;
                end else begin
                    i_d     = i_q + IW'(1);
                    state_d = StMac;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // busy/done are registered, so they trail the state by one cycle: busy
    // rises the cycle after start is taken and done lands after the DONE state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int r = 0; r < int'(M); r++) begin
                z_q[r][0] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            busy_q  <= (state_q != StIdle);
            done_q  <= (state_q == StDone);
            if (z_we) begin
                z_q[i_q][0] <= z_val;
            end
        end
    end

    assign bus.z    = z_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_dense_forward.sv
// tb_dense_forward: table-driven and scoreboard checks for dense_forward.
// A small instance (M=2, N=3) runs the directed vectors and handshake/reset
// sequences; a default instance (M=5, N=4) runs random passes against a model.
// Honours DENSE_SATURATE_EN for the expected values of overflowing results.
module tb_dense_forward;
    localparam int unsigned SM = 2;
    localparam int unsigned SN = 3;
    localparam int unsigned LM = 5;
    localparam int unsigned LN = 4;
    localparam int unsigned FB = 12;
    localparam int SLat = 1 + SM * (SN + 1);
    localparam int LLat = 1 + LM * (LN + 1);
    localparam int IntMin = int'(32'h8000_0000);
    localparam int IntMax = 32'sh7fff_ffff;
`ifdef DENSE_SATURATE_EN
    localparam int ExpSatPos = IntMax;
    localparam int ExpSatNeg = IntMin;
    localparam int ExpEdge   = IntMax;
`else
    localparam int ExpSatPos = 0;
    localparam int ExpSatNeg = 0;
    localparam int ExpEdge   = IntMin;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_s[$];
    int   exp_l[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dense_forward_if #(.M(SM), .N(SN)) if_s ();
    dense_forward_if #(.M(LM), .N(LN)) if_l ();

    dense_forward #(.M(SM), .N(SN), .FRAC_BITS(FB)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (if_s.slave)
    );

    dense_forward #(.M(LM), .N(LN), .FRAC_BITS(FB)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l.slave)
    );

    typedef struct {
        string name;
        int    x [SN];
        int    w [SM][SN];
        int    b [SM];
        int    z [SM];
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Bit-accurate reference for one row of the default instance.
    function automatic int ref_row(input int x [LN], input int w [LM][LN],
                                   input int b [LM], input int i);
        logic signed [66:0] acc;
        logic signed [66:0] s;
        acc = '0;
        for (int j = 0; j < int'(LN); j++) begin
            acc = acc + 67'(longint'(x[j]) * longint'(w[i][j]));
        end
        s = (acc >>> FB) + 67'(longint'(b[i]));
`ifdef DENSE_SATURATE_EN
        if (s > 67'sd2147483647) return IntMax;
        if (s < -67'sd2147483648) return IntMin;
`endif
        return int'(s[31:0]);
    endfunction

    // One pass on the small instance; optionally re-pulses start mid-pass.
    task automatic run_small(input vec_t v, input int repulse_at);
        int k;
        int d;
        bit got;
        for (int j = 0; j < int'(SN); j++) if_s.x[j][0] = v.x[j];
        for (int i = 0; i < int'(SM); i++) begin
            for (int j = 0; j < int'(SN); j++) if_s.w[i][j] = v.w[i][j];
            if_s.b[i][0] = v.b[i];
            exp_s.push_back(v.z[i]);
        end
        @(negedge clk);
        if_s.start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        if_s.start = 1'b0;
        got = 1'b0;
        d = 0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if_s.start = (c == repulse_at);
            if (if_s.done) begin
                got = 1'b1;
                d = cyc;
            end
        end
        if_s.start = 1'b0;
        check($sformatf("%s latency", v.name), got ? d - k : -1, SLat);
        for (int r = 0; r < int'(SM); r++) begin
            check($sformatf("%s z%0d", v.name, r), if_s.z[r][0], exp_s.pop_front());
        end
    endtask

    task automatic run_large(input int x [LN], input int w [LM][LN], input int b [LM],
                             input bit chk_lat);
        int k;
        int d;
        bit got;
        for (int j = 0; j < int'(LN); j++) if_l.x[j][0] = x[j];
        for (int i = 0; i < int'(LM); i++) begin
            for (int j = 0; j < int'(LN); j++) if_l.w[i][j] = w[i][j];
            if_l.b[i][0] = b[i];
            exp_l.push_back(ref_row(x, w, b, i));
        end
        @(negedge clk);
        if_l.start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        if_l.start = 1'b0;
        got = 1'b0;
        d = 0;
        for (int c = 1; c <= 100 && !got; c++) begin
            @(negedge clk);
            if (if_l.done) begin
                got = 1'b1;
                d = cyc;
            end
        end
        if (!got || chk_lat) check("large latency", got ? d - k : -1, LLat);
        for (int r = 0; r < int'(LM); r++) begin
            check($sformatf("large z%0d", r), if_l.z[r][0], exp_l.pop_front());
        end
    endtask

    function automatic int rnd_val(input int mode);
        case (mode)
            0:       return int'($urandom());
            1:       return int'($urandom_range(65535)) - 32768;
            default: return int'($urandom_range(2097151)) - 1048576;
        endcase
    endfunction

    initial begin
        int dc [3];
        int cnt;
        int k;
        int lx [LN];
        int lw [LM][LN];
        int lb [LM];

        if_s.start = 1'b0;
        if_l.start = 1'b0;
        for (int j = 0; j < int'(SN); j++) if_s.x[j][0] = 0;
        for (int i = 0; i < int'(SM); i++) begin
            for (int j = 0; j < int'(SN); j++) if_s.w[i][j] = 0;
            if_s.b[i][0] = 0;
        end
        for (int j = 0; j < int'(LN); j++) if_l.x[j][0] = 0;
        for (int i = 0; i < int'(LM); i++) begin
            for (int j = 0; j < int'(LN); j++) if_l.w[i][j] = 0;
            if_l.b[i][0] = 0;
        end

        vecs[0].name = "basic";
        vecs[0].x = '{4096, 8192, 2048};
        vecs[0].w = '{'{4096, 4096, 4096}, '{-4096, 2048, 8192}};
        vecs[0].b = '{4096, -8192};
        vecs[0].z = '{18432, -4096};
        vecs[1].name = "trunc_pos";
        vecs[1].x = '{1, 1, 1};
        vecs[1].w = '{'{1, 1, 1}, '{1, 1, 1}};
        vecs[1].b = '{0, 0};
        vecs[1].z = '{0, 0};
        vecs[2].name = "trunc_neg";
        vecs[2].x = '{1, 0, 0};
        vecs[2].w = '{'{-1, 0, 0}, '{0, 0, 0}};
        vecs[2].b = '{0, 0};
        vecs[2].z = '{-1, 0};
        vecs[3].name = "sat_pos";
        vecs[3].x = '{1 << 30, 0, 0};
        vecs[3].w = '{'{1 << 30, 0, 0}, '{0, 0, 0}};
        vecs[3].b = '{0, 0};
        vecs[3].z = '{ExpSatPos, 0};
        vecs[4].name = "sat_neg";
        vecs[4].x = '{1 << 30, 0, 0};
        vecs[4].w = '{'{-(1 << 30), 0, 0}, '{0, 0, 0}};
        vecs[4].b = '{0, 0};
        vecs[4].z = '{ExpSatNeg, 0};
        vecs[5].name = "bias_mix";
        vecs[5].x = '{-4096, 4096, 12288};
        vecs[5].w = '{'{4096, -8192, 2048}, '{0, 0, -4096}};
        vecs[5].b = '{100, -100};
        vecs[5].z = '{-6044, -12388};
        // Row 0 lands one past the positive limit; row 1 exactly on the negative one.
        vecs[6].name = "edge";
        vecs[6].x = '{1 << 30, 0, 0};
        vecs[6].w = '{'{8192, 0, 0}, '{-8192, 0, 0}};
        vecs[6].b = '{0, 0};
        vecs[6].z = '{ExpEdge, IntMin};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy_s", if_s.busy, 0);
        check("reset done_s", if_s.done, 0);
        check("reset z0_s", if_s.z[0][0], 0);
        check("reset z1_s", if_s.z[1][0], 0);
        check("reset busy_l", if_l.busy, 0);
        check("reset z4_l", if_l.z[4][0], 0);
        reset = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 7; t++) run_small(vecs[t], 0);

        // start re-pulsed while busy: same result and latency, no extra pass.
        run_small(vecs[0], 3);
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (if_s.done) cnt++;
        end
        check("repulse extra done", cnt, 0);

        // start held high: back-to-back passes.
        run_small(vecs[5], 0);
        for (int j = 0; j < int'(SN); j++) if_s.x[j][0] = vecs[0].x[j];
        for (int i = 0; i < int'(SM); i++) begin
            for (int j = 0; j < int'(SN); j++) if_s.w[i][j] = vecs[0].w[i][j];
            if_s.b[i][0] = vecs[0].b[i];
        end
        dc = '{0, 0, 0};
        cnt = 0;
        @(negedge clk);
        if_s.start = 1'b1;
        for (int c = 0; c < 80 && cnt < 3; c++) begin
            @(negedge clk);
            if (if_s.done) begin
                dc[cnt] = cyc;
                check($sformatf("hold z0 #%0d", cnt), if_s.z[0][0], 18432);
                check($sformatf("hold z1 #%0d", cnt), if_s.z[1][0], -4096);
                cnt++;
                if (cnt == 3) if_s.start = 1'b0;
            end
        end
        if_s.start = 1'b0;
        check("hold pulse count", cnt, 3);
        check("hold spacing 1", dc[1] - dc[0], SM * (SN + 1) + 2);
        check("hold spacing 2", dc[2] - dc[1], SM * (SN + 1) + 2);
        repeat (3) @(negedge clk);
        check("hold idle after", if_s.busy, 0);

        // Reset during the MAC cycles of row 1; z holds the basic result before it.
        @(negedge clk);
        if_s.start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        if_s.start = 1'b0;
        repeat (6) @(negedge clk);
        check("midreset busy before", if_s.busy, 1);
        check("midreset cycle", cyc - k, 5);
        reset = 1'b0;
        @(negedge clk);
        check("midreset busy", if_s.busy, 0);
        check("midreset done", if_s.done, 0);
        check("midreset z0", if_s.z[0][0], 0);
        check("midreset z1", if_s.z[1][0], 0);
        reset = 1'b1;
        @(negedge clk);
        run_small(vecs[0], 0);

        // Default configuration, random data against the model.
        for (int p = 0; p < 1000; p++) begin
            for (int j = 0; j < int'(LN); j++) lx[j] = rnd_val(p % 3);
            for (int i = 0; i < int'(LM); i++) begin
                for (int j = 0; j < int'(LN); j++) lw[i][j] = rnd_val(p % 3);
                lb[i] = (p % 2 == 0) ? int'($urandom()) : rnd_val(1);
            end
            run_large(lx, lw, lb, p < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
